stream_fifo: RTL and testbench

- Parametrised first-word-fall-through FIFO; next generation of the team's simple buffer.
- Adds the following over the simple buffer:
  - occupancy count
  - programmable almost-full/almost-empty flags
  - synchronous flush
  - sticky overflow/underflow error flags
  - read-while-full acceptance
- Used between the systolic-array data movers and memory-side interfaces, where backpressure needs early warning and debug needs error visibility.

---
 rtl/stream_fifo.sv | 77 +++++++
 tb/tb_stream_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through FIFO with occupancy, threshold flags, flush and sticky errors
module stream_fifo #(
  parameter  int DEPTH  = 8,
  parameter  int DWIDTH = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] din,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  input  logic [AW:0]       af_thresh,
  input  logic [AW:0]       ae_thresh,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [AW:0]       w_count;

  // Extra wrap bit on each pointer distinguishes full from empty when the indices match.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_count  = r_wptr - r_rptr;
  assign w_rd_acc = rd_en && !w_empty;
  assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      if (wr_en && !w_wr_acc) r_overflow  <= 1'b1;
      if (rd_en && !w_rd_acc) r_underflow <= 1'b1;
    end
  end

  // Storage carries no reset; a flush cycle must not deposit din.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !flush) r_mem[r_wptr[AW-1:0]] <= din;
  end

  assign dout         = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign empty        = w_empty;
  assign full         = w_full;
  assign count        = w_count;
  assign almost_full  = (w_count >= af_thresh);
  assign almost_empty = (w_count <= ae_thresh);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - vector table, corner sequences and randomized queue-model checks for stream_fifo
module tb_stream_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] din = '0;
  logic        rd_en = 1'b0;
  logic [15:0] dout;
  logic        empty, full, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;
  logic [3:0]  af_thresh = 4'd6;
  logic [3:0]  ae_thresh = 4'd2;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mq[$];
  bit          m_ovf, m_unf;

  typedef struct {
    logic        wr;
    logic [15:0] d;
    logic        rd;
    logic        fl;
    logic [3:0]  cnt;
    logic [15:0] dout;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  stream_fifo #(.DEPTH(8), .DWIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(logic wr, logic [15:0] d, logic rd, logic fl, logic [3:0] cnt,
                               logic [15:0] dv, logic f, logic e, logic af, logic ae,
                               logic ovf, logic unf);
    vec_t v;
    v.wr = wr; v.d = d; v.rd = rd; v.fl = fl; v.cnt = cnt; v.dout = dv;
    v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  // One clock: drive, let the edge happen, advance the reference queue, settle.
  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic f);
    bit m_e, m_f, ra, wa;
    wr_en = w; din = d; rd_en = r; flush = f;
    @(posedge clk);
    m_e = (mq.size() == 0);
    m_f = (mq.size() == 8);
    ra  = r && !m_e;
    wa  = w && (!m_f || ra);
    if (f) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (ra) void'(mq.pop_front());
      if (wa) mq.push_back(d);
      if (w && !wa) m_ovf = 1;
      if (r && !ra) m_unf = 1;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"},  dout,  (mq.size() != 0) ? mq[0] : 16'h0);
    chk({tag, ".count"}, count, mq.size());
    chk({tag, ".empty"}, empty, mq.size() == 0);
    chk({tag, ".full"},  full,  mq.size() == 8);
    chk({tag, ".af"},    almost_full,  mq.size() >= int'(af_thresh));
    chk({tag, ".ae"},    almost_empty, mq.size() <= int'(ae_thresh));
    chk({tag, ".ovf"},   overflow,  m_ovf);
    chk({tag, ".unf"},   underflow, m_unf);
  endtask

  initial begin
    // Fill, overflow, read-while-full, drain, write+read on empty, flush with wr_en.
    vecs.push_back(mkv(1, 16'h0001, 0, 0, 1, 16'h0001, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(1, 16'h0002, 0, 0, 2, 16'h0001, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(1, 16'h0003, 0, 0, 3, 16'h0001, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 16'h0004, 0, 0, 4, 16'h0001, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 16'h0005, 0, 0, 5, 16'h0001, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 16'h0006, 0, 0, 6, 16'h0001, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 16'h0007, 0, 0, 7, 16'h0001, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 16'h0008, 0, 0, 8, 16'h0001, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 16'h0009, 0, 0, 8, 16'h0001, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mkv(1, 16'h00AA, 1, 0, 8, 16'h0002, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 16'h0000, 1, 0, 7, 16'h0003, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 16'h0000, 1, 0, 6, 16'h0004, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 16'h0000, 1, 0, 5, 16'h0005, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 16'h0000, 1, 0, 4, 16'h0006, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 16'h0000, 1, 0, 3, 16'h0007, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 16'h0000, 1, 0, 2, 16'h0008, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mkv(0, 16'h0000, 1, 0, 1, 16'h00AA, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mkv(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mkv(1, 16'h0055, 1, 0, 1, 16'h0055, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mkv(1, 16'h0077, 0, 1, 0, 16'h0000, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 0, 0));

    m_ovf = 0;
    m_unf = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.empty", empty, 1'b1);
    chk("reset.full",  full,  1'b0);
    chk("reset.count", count, 4'd0);
    chk("reset.dout",  dout,  16'h0);
    chk("reset.ovf",   overflow,  1'b0);
    chk("reset.unf",   underflow, 1'b0);
    chk("reset.ae",    almost_empty, 1'b1);
    chk("reset.af",    almost_full,  1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].fl);
      chk({t, ".count"}, count, vecs[i].cnt);
      chk({t, ".dout"},  dout,  vecs[i].dout);
      chk({t, ".full"},  full,  vecs[i].full);
      chk({t, ".empty"}, empty, vecs[i].empty);
      chk({t, ".af"},    almost_full,  vecs[i].af);
      chk({t, ".ae"},    almost_empty, vecs[i].ae);
      chk({t, ".ovf"},   overflow,  vecs[i].ovf);
      chk({t, ".unf"},   underflow, vecs[i].unf);
    end

    // Streaming: every word read one cycle after its write, walking the pointers round twice.
    step(1, 16'h1000, 0, 0);
    check_model("stream0");
    for (int k = 1; k < 20; k++) begin
      step(1, 16'h1000 + 16'(k), 1, 0);
      check_model($sformatf("stream%0d", k));
      chk($sformatf("stream%0d.head", k), dout, 16'h1000 + 16'(k));
    end
    step(0, 16'h0, 1, 0);
    check_model("stream_end");

    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        af_thresh = 4'($urandom_range(0, 10));
        ae_thresh = 4'($urandom_range(0, 10));
      end
      step($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 199) == 0);
      check_model($sformatf("rand%0d", n));
    end

    // Asynchronous reset in the middle of a burst, with an overflow already recorded.
    af_thresh = 4'd0;
    ae_thresh = 4'd2;
    for (int k = 0; k < 10; k++) step(1, 16'h2000 + 16'(k), 0, 0);
    check_model("prerst");
    #2;
    rst = 1'b1;
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    #1;
    chk("asyncrst.empty", empty, 1'b1);
    chk("asyncrst.full",  full,  1'b0);
    chk("asyncrst.count", count, 4'd0);
    chk("asyncrst.dout",  dout,  16'h0);
    chk("asyncrst.ovf",   overflow, 1'b0);
    chk("asyncrst.af",    almost_full, 1'b1);
    chk("asyncrst.ae",    almost_empty, 1'b1);
    af_thresh = 4'd6;
    @(negedge clk);
    rst = 1'b0;
    step(1, 16'h3333, 0, 0);
    check_model("postrst");
    step(0, 16'h0, 1, 0);
    check_model("postrst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
